cpu_step_3: RTL and testbench

//  Write-back stage of the tetris CPU pipeline. It takes the candidate piece position computed
//  by stage 2 and checks it against the field bitmap. It then returns the committed coordinates,
//  the updated field and the control strobes to stage 1. These strobes are is_load_PC,
//  is_write_reg and is_touch, and they close the step_1 -> step_2 -> step_3 loop.
//  On a blocked downward move, the piece is merged into the field and a new piece is spawned.

---
 rtl/cpu_step_3.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_cpu_step_3.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_step_3.sv
// cpu_step_3 -- write-back stage of the tetris CPU pipeline.
// Checks the stage-2 candidate piece position against the field bitmap, commits either the
// candidate or the old position, or lands the piece (merge into field, respawn) on a blocked
// downward move. Hands coordinates, field and the is_load_PC/is_write_reg/is_touch strobes
// back to stage 1.
// Optional feature macro: ROW_CLEAR_EN -- enables the CLEAR state that removes full rows
// after a landing (scanned bottom-up, one row per cycle).
module cpu_step_3 #(
  parameter int                 MEM_WIDTH     = 4,
  parameter int                 WIDTH         = 8,
  parameter logic [WIDTH*4-1:0] SPAWN_COORD_X = 32'h04030403,
  parameter logic [WIDTH*4-1:0] SPAWN_COORD_Y = 32'h01010000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_step_2,
  output logic                       ready_step_3,
  input  logic                       move_down_step_2,
  input  logic [WIDTH*4-1:0]         coord_x_step_2,
  input  logic [WIDTH*4-1:0]         coord_y_step_2,
  input  logic [WIDTH*4-1:0]         cand_coord_x_step_2,
  input  logic [WIDTH*4-1:0]         cand_coord_y_step_2,
  input  logic [WIDTH*MEM_WIDTH-1:0] bus_step_2,
  output logic [WIDTH*4-1:0]         new_coord_x_step_3,
  output logic [WIDTH*4-1:0]         new_coord_y_step_3,
  output logic [WIDTH*MEM_WIDTH-1:0] new_bus_step_3,
  output logic                       is_load_PC,
  output logic                       is_write_reg,
  output logic                       is_touch
);

  localparam int CW = WIDTH * 4;
  localparam int FW = WIDTH * MEM_WIDTH;

`ifdef ROW_CLEAR_EN
  localparam int RW = (MEM_WIDTH > 1) ? $clog2(MEM_WIDTH) : 1;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RESP  = 3'd2,
    MERGE = 3'd3,
    CLEAR = 3'd4,
    DONE  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RESP  = 3'd2,
    MERGE = 3'd3,
    DONE  = 3'd5
  } state_t;
`endif

  // A cell is blocked when it lies outside the field or lands on an occupied bit.
  // Matching against every legal (row, col) pair keeps all field indices constant, and a
  // coordinate that matches nothing (including wrapped 8'hFF) is out of bounds.
  function automatic logic cell_blocked(input logic [FW-1:0] f,
                                        input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
    logic found;
    logic occ;
    found = 1'b0;
    occ   = 1'b0;
    for (int r = 0; r < MEM_WIDTH; r++) begin
      for (int c = 0; c < WIDTH; c++) begin
        if ((x == c[WIDTH-1:0]) && (y == r[WIDTH-1:0])) begin
          found = 1'b1;
          occ   = f[r*WIDTH + c];
        end
      end
    end
    return (!found) || occ;
  endfunction

  // True when any of the four cells of a piece is blocked.
  function automatic logic any_blocked(input logic [FW-1:0] f,
                                       input logic [CW-1:0] xs,
                                       input logic [CW-1:0] ys);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hit = hit | cell_blocked(f, xs[i*WIDTH +: WIDTH], ys[i*WIDTH +: WIDTH]);
    end
    return hit;
  endfunction

  // Set the field bits under the four cells; duplicate or off-field cells are harmless.
  function automatic logic [FW-1:0] merge_cells(input logic [FW-1:0] f,
                                                input logic [CW-1:0] xs,
                                                input logic [CW-1:0] ys);
    logic [FW-1:0] m;
    m = f;
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < MEM_WIDTH; r++) begin
        for (int c = 0; c < WIDTH; c++) begin
          if ((xs[i*WIDTH +: WIDTH] == c[WIDTH-1:0]) && (ys[i*WIDTH +: WIDTH] == r[WIDTH-1:0])) begin
            m[r*WIDTH + c] = 1'b1;
          end
        end
      end
    end
    return m;
  endfunction

`ifdef ROW_CLEAR_EN
  // True when the selected row has every column occupied.
  function automatic logic row_full(input logic [FW-1:0] f, input logic [RW-1:0] row);
    logic full;
    full = 1'b0;
    for (int r = 0; r < MEM_WIDTH; r++) begin
      if (int'(row) == r) begin
        full = &f[r*WIDTH +: WIDTH];
      end
    end
    return full;
  endfunction

  // Remove the selected row: rows above it move down one, the top row becomes empty.
  function automatic logic [FW-1:0] drop_row(input logic [FW-1:0] f, input logic [RW-1:0] row);
    logic [FW-1:0] d;
    d = {FW{1'b0}};
    for (int k = 1; k < MEM_WIDTH; k++) begin
      if (k <= int'(row)) begin
        d[k*WIDTH +: WIDTH] = f[(k-1)*WIDTH +: WIDTH];
      end else begin
        d[k*WIDTH +: WIDTH] = f[k*WIDTH +: WIDTH];
      end
    end
    return d;
  endfunction
`endif

  state_t state_r;
  state_t state_s;

  logic            move_down_r;
  logic [CW-1:0]   old_x_r;
  logic [CW-1:0]   old_y_r;
  logic [CW-1:0]   cand_x_r;
  logic [CW-1:0]   cand_y_r;
  logic [FW-1:0]   field_r;
  logic [FW-1:0]   field_s;
  logic [CW-1:0]   coord_x_r;
  logic [CW-1:0]   coord_x_s;
  logic [CW-1:0]   coord_y_r;
  logic [CW-1:0]   coord_y_s;
  logic [FW-1:0]   bus_r;
  logic [FW-1:0]   bus_s;
  logic            load_pc_r;
  logic            load_pc_s;
  logic            write_reg_r;
  logic            write_reg_s;
  logic            touch_r;
  logic            touch_s;
  logic            xfer_s;
  logic            blocked_s;
`ifdef ROW_CLEAR_EN
  logic [RW-1:0]   row_r;
  logic [RW-1:0]   row_s;
`endif

  assign ready_step_3       = (state_r == IDLE);
  assign xfer_s             = valid_step_2 & ready_step_3;
  assign blocked_s          = any_blocked(field_r, cand_x_r, cand_y_r);

  assign new_coord_x_step_3 = coord_x_r;
  assign new_coord_y_step_3 = coord_y_r;
  assign new_bus_step_3     = bus_r;
  assign is_load_PC         = load_pc_r;
  assign is_write_reg       = write_reg_r;
  assign is_touch           = touch_r;

  // Capture the stage-2 transaction on the handshake edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      move_down_r <= 1'b0;
      old_x_r     <= {CW{1'b0}};
      old_y_r     <= {CW{1'b0}};
      cand_x_r    <= {CW{1'b0}};
      cand_y_r    <= {CW{1'b0}};
    end else if (xfer_s) begin
      move_down_r <= move_down_step_2;
      old_x_r     <= coord_x_step_2;
      old_y_r     <= coord_y_step_2;
      cand_x_r    <= cand_coord_x_step_2;
      cand_y_r    <= cand_coord_y_step_2;
    end
  end

  // Next-state, working-field and output-register logic of the write-back FSM.
  always_comb begin
    state_s     = state_r;
    field_s     = field_r;
    coord_x_s   = coord_x_r;
    coord_y_s   = coord_y_r;
    bus_s       = bus_r;
    load_pc_s   = 1'b0;
    write_reg_s = 1'b0;
    touch_s     = 1'b0;
`ifdef ROW_CLEAR_EN
    row_s       = row_r;
`endif
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          field_s = bus_step_2;
          state_s = CHECK;
        end else begin
          state_s = IDLE;
        end
      end
      CHECK: begin
        if (!blocked_s) begin
          coord_x_s   = cand_x_r;
          coord_y_s   = cand_y_r;
          load_pc_s   = 1'b1;
          write_reg_s = 1'b1;
          state_s     = RESP;
        end else if (!move_down_r) begin
          coord_x_s   = old_x_r;
          coord_y_s   = old_y_r;
          load_pc_s   = 1'b1;
          write_reg_s = 1'b1;
          state_s     = RESP;
        end else begin
          state_s = MERGE;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      MERGE: begin
        field_s = merge_cells(field_r, old_x_r, old_y_r);
`ifdef ROW_CLEAR_EN
        row_s   = RW'(MEM_WIDTH - 1);
        state_s = CLEAR;
`else
        // Landing without row clearing: publish the merged field straight away.
        coord_x_s   = SPAWN_COORD_X;
        coord_y_s   = SPAWN_COORD_Y;
        bus_s       = field_s;
        load_pc_s   = 1'b1;
        write_reg_s = 1'b1;
        touch_s     = 1'b1;
        state_s     = DONE;
`endif
      end
`ifdef ROW_CLEAR_EN
      CLEAR: begin
        if (row_full(field_r, row_r)) begin
          // Same row index is rescanned: the row that slid into it may also be full.
          field_s = drop_row(field_r, row_r);
          state_s = CLEAR;
        end else if (row_r == {RW{1'b0}}) begin
          coord_x_s   = SPAWN_COORD_X;
          coord_y_s   = SPAWN_COORD_Y;
          bus_s       = field_r;
          load_pc_s   = 1'b1;
          write_reg_s = 1'b1;
          touch_s     = 1'b1;
          state_s     = DONE;
        end else begin
          row_s   = row_r - RW'(1);
          state_s = CLEAR;
        end
      end
`endif
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, working field and registered outputs; reset aborts any operation silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      field_r     <= {FW{1'b0}};
      coord_x_r   <= SPAWN_COORD_X;
      coord_y_r   <= SPAWN_COORD_Y;
      bus_r       <= {FW{1'b0}};
      load_pc_r   <= 1'b0;
      write_reg_r <= 1'b0;
      touch_r     <= 1'b0;
`ifdef ROW_CLEAR_EN
      row_r       <= {RW{1'b0}};
`endif
    end else begin
      state_r     <= state_s;
      field_r     <= field_s;
      coord_x_r   <= coord_x_s;
      coord_y_r   <= coord_y_s;
      bus_r       <= bus_s;
      load_pc_r   <= load_pc_s;
      write_reg_r <= write_reg_s;
      touch_r     <= touch_s;
`ifdef ROW_CLEAR_EN
      row_r       <= row_s;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_step_3.sv
// Directed testbench for cpu_step_3: reset, legal move, wall/collision/underflow rejects,
// landing, row handling (depends on ROW_CLEAR_EN) and reset in the middle of a landing.
module tb_cpu_step_3;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_step_2;
  logic        ready_step_3;
  logic        move_down_step_2;
  logic [31:0] coord_x_step_2;
  logic [31:0] coord_y_step_2;
  logic [31:0] cand_coord_x_step_2;
  logic [31:0] cand_coord_y_step_2;
  logic [31:0] bus_step_2;
  logic [31:0] new_coord_x_step_3;
  logic [31:0] new_coord_y_step_3;
  logic [31:0] new_bus_step_3;
  logic        is_load_PC;
  logic        is_write_reg;
  logic        is_touch;

  int errors = 0;
  int checks = 0;
  int lat;

  localparam logic [31:0] SPAWN_X = 32'h04030403;
  localparam logic [31:0] SPAWN_Y = 32'h01010000;

`ifdef ROW_CLEAR_EN
  localparam int LAND_LAT   = 6;
  localparam int CLEAR_LAT  = 7;
  localparam logic [31:0] CLEAR_BUS = 32'h18000000;
`else
  localparam int LAND_LAT   = 2;
  localparam int CLEAR_LAT  = 2;
  localparam logic [31:0] CLEAR_BUS = 32'hFF180000;
`endif

  always #5 clk = ~clk;

  cpu_step_3 dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_step_2        (valid_step_2),
    .ready_step_3        (ready_step_3),
    .move_down_step_2    (move_down_step_2),
    .coord_x_step_2      (coord_x_step_2),
    .coord_y_step_2      (coord_y_step_2),
    .cand_coord_x_step_2 (cand_coord_x_step_2),
    .cand_coord_y_step_2 (cand_coord_y_step_2),
    .bus_step_2          (bus_step_2),
    .new_coord_x_step_3  (new_coord_x_step_3),
    .new_coord_y_step_3  (new_coord_y_step_3),
    .new_bus_step_3      (new_bus_step_3),
    .is_load_PC          (is_load_PC),
    .is_write_reg        (is_write_reg),
    .is_touch            (is_touch)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one candidate and complete the handshake; returns just after the transfer edge.
  task automatic send(input logic mv, input logic [31:0] ox, input logic [31:0] oy,
                      input logic [31:0] cx, input logic [31:0] cy, input logic [31:0] b);
    move_down_step_2    = mv;
    coord_x_step_2      = ox;
    coord_y_step_2      = oy;
    cand_coord_x_step_2 = cx;
    cand_coord_y_step_2 = cy;
    bus_step_2          = b;
    valid_step_2        = 1'b1;
    tick();
    valid_step_2        = 1'b0;
  endtask

  // Count cycles after the transfer edge until is_write_reg rises (bounded).
  task automatic wait_strobe(output int n);
    n = 0;
    while ((is_write_reg !== 1'b1) && (n < 40)) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst                 = 1'b1;
    valid_step_2        = 1'b0;
    move_down_step_2    = 1'b0;
    coord_x_step_2      = 32'h0;
    coord_y_step_2      = 32'h0;
    cand_coord_x_step_2 = 32'h0;
    cand_coord_y_step_2 = 32'h0;
    bus_step_2          = 32'h0;
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_x", new_coord_x_step_3, SPAWN_X);
    chk("rst_y", new_coord_y_step_3, SPAWN_Y);
    chk("rst_bus", new_bus_step_3, 32'h0);
    chk("rst_load", is_load_PC, 1'b0);
    chk("rst_write", is_write_reg, 1'b0);
    chk("rst_touch", is_touch, 1'b0);
    chk("rst_ready", ready_step_3, 1'b1);

    // Legal downward move into an empty field
    send(1'b1, SPAWN_X, SPAWN_Y, 32'h04030403, 32'h02020101, 32'h0);
    chk("legal_busy", ready_step_3, 1'b0);
    wait_strobe(lat);
    chk("legal_lat", lat, 1);
    chk("legal_x", new_coord_x_step_3, 32'h04030403);
    chk("legal_y", new_coord_y_step_3, 32'h02020101);
    chk("legal_load", is_load_PC, 1'b1);
    chk("legal_touch", is_touch, 1'b0);
    chk("legal_bus", new_bus_step_3, 32'h0);
    tick();
    chk("legal_write_end", is_write_reg, 1'b0);
    chk("legal_ready", ready_step_3, 1'b1);

    // Right wall: x=8 is out of bounds, sideways move is rejected
    send(1'b0, 32'h07060706, 32'h02020101, 32'h08070807, 32'h02020101, 32'h00000001);
    wait_strobe(lat);
    chk("wall_lat", lat, 1);
    chk("wall_x", new_coord_x_step_3, 32'h07060706);
    chk("wall_y", new_coord_y_step_3, 32'h02020101);
    chk("wall_load", is_load_PC, 1'b1);
    chk("wall_touch", is_touch, 1'b0);
    chk("wall_bus", new_bus_step_3, 32'h0);
    tick();
    chk("wall_ready", ready_step_3, 1'b1);

    // Collision with an occupied cell (row 1, col 2) on a left move
    send(1'b0, 32'h04030403, 32'h02020101, 32'h03020302, 32'h02020101, 32'h00000400);
    wait_strobe(lat);
    chk("coll_x", new_coord_x_step_3, 32'h04030403);
    chk("coll_touch", is_touch, 1'b0);
    tick();

    // Left wall: 0-1 wraps to 8'hFF, which is out of bounds
    send(1'b0, 32'h01000100, 32'h02020101, 32'h00FF00FF, 32'h02020101, 32'h0);
    wait_strobe(lat);
    chk("under_x", new_coord_x_step_3, 32'h01000100);
    chk("under_touch", is_touch, 1'b0);
    tick();

    // Landing on the floor: old cells merged, respawn
    send(1'b1, 32'h04030403, 32'h03030202, 32'h04030403, 32'h04040303, 32'h0);
    chk("land_no_early", is_write_reg, 1'b0);
    wait_strobe(lat);
    chk("land_lat", lat, LAND_LAT);
    chk("land_touch", is_touch, 1'b1);
    chk("land_load", is_load_PC, 1'b1);
    chk("land_bus", new_bus_step_3, 32'h18180000);
    chk("land_x", new_coord_x_step_3, SPAWN_X);
    chk("land_y", new_coord_y_step_3, SPAWN_Y);
    tick();
    chk("land_touch_end", is_touch, 1'b0);
    chk("land_ready", ready_step_3, 1'b1);
    chk("land_bus_hold", new_bus_step_3, 32'h18180000);

    // Landing that completes row 3
    send(1'b1, 32'h04030403, 32'h03030202, 32'h04030403, 32'h04040303, 32'hE7000000);
    wait_strobe(lat);
    chk("clr_lat", lat, CLEAR_LAT);
    chk("clr_touch", is_touch, 1'b1);
    chk("clr_bus", new_bus_step_3, CLEAR_BUS);
    tick();
    chk("clr_ready", ready_step_3, 1'b1);

    // Reset while the landing is still in progress
    send(1'b1, 32'h04030403, 32'h03030202, 32'h04030403, 32'h04040303, 32'hE7000000);
    tick();
`ifdef ROW_CLEAR_EN
    tick();
`endif
    chk("abort_pre_touch", is_touch, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", ready_step_3, 1'b1);
    chk("abort_bus", new_bus_step_3, 32'h0);
    chk("abort_x", new_coord_x_step_3, SPAWN_X);
    chk("abort_y", new_coord_y_step_3, SPAWN_Y);
    for (int i = 0; i < 4; i++) begin
      chk("abort_touch", is_touch, 1'b0);
      chk("abort_write", is_write_reg, 1'b0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
